// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin two-port arbiter driving a single-ported async SRAM
module sram_arbiter #(
  parameter int ACC_CYC = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_req,
  input  logic [1:0]  i_we,
  input  logic [39:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [1:0]  o_gnt,
  output logic [15:0] o_rdata,
  output logic [1:0]  o_rvalid,
  output logic        o_busy,
  output logic        o_sram_rd,
  output logic        o_sram_wr,
  output logic [19:0] o_sram_addr,
  inout  wire  [15:0] sram_dq
);
  typedef enum logic {IDLE, ACC} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic last_acc, take, pick, rr_last, port, we;
  logic [15:0] wdata;
  assign last_acc = state == ACC && cnt == 4'(ACC_CYC - 1);
  assign take = (state == IDLE || last_acc) && |i_req;
  assign pick = &i_req ? ~rr_last : i_req[1];
  // next state: a grant (re)starts an access, otherwise the last cycle falls back to idle
  always_comb begin
    state_n = take ? ACC : (last_acc ? IDLE : state);
    cnt_n = (take || last_acc) ? 4'd0 : (state == ACC ? cnt + 4'd1 : cnt);
  end
  // state register; reset aborts any access in flight
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= IDLE;
      cnt <= 4'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  // grant latching, read capture and single-cycle pulses; rr_last=1 makes port 0 win the first tie
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      rr_last <= 1'b1;
      port <= 1'b0;
      we <= 1'b0;
      wdata <= 16'd0;
      o_sram_addr <= 20'd0;
      o_gnt <= 2'b00;
      o_rvalid <= 2'b00;
      o_rdata <= 16'd0;
    end else begin
      o_gnt <= take ? (pick ? 2'b10 : 2'b01) : 2'b00;
      o_rvalid <= (last_acc && !we) ? (port ? 2'b10 : 2'b01) : 2'b00;
      if (last_acc && !we) o_rdata <= sram_dq;
      if (take) begin
        port <= pick;
        rr_last <= pick;
        we <= i_we[pick];
        o_sram_addr <= pick ? i_addr[39:20] : i_addr[19:0];
        wdata <= pick ? i_wdata[31:16] : i_wdata[15:0];
      end
    end
  assign o_busy = state == ACC;
  assign o_sram_rd = o_busy & ~we;
  assign o_sram_wr = o_busy & we;
  assign sram_dq = o_sram_wr ? wdata : 16'hzzzz;
endmodule
